// File: rtl/cmd_response_deserializer_pkg.sv
// rtl/cmd_response_deserializer_pkg.sv - shared encodings, frame lengths and CRC7 step for the CMD response path
package cmd_response_deserializer_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'b0001,
        S_WAIT_START = 4'b0010,
        S_RECEIVE    = 4'b0100,
        S_DONE       = 4'b1000
    } state_e;

    localparam int SHORT_LEN = 48;
    localparam int LONG_LEN  = 136;
    localparam int FRAME_W   = 128;
    localparam int CNT_W     = 8;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Count values are "bits received so far"; the start bit leaves the counter at 1.
    localparam logic [CNT_W-1:0] SHORT_LAST_CNT     = CNT_W'(SHORT_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST_CNT      = CNT_W'(LONG_LEN - 1);
    localparam logic [CNT_W-1:0] SHORT_CRC_LAST_CNT = CNT_W'(SHORT_LEN - 9);
    localparam logic [CNT_W-1:0] LONG_CRC_FIRST_CNT = CNT_W'(LONG_LEN - FRAME_W);
    localparam logic [CNT_W-1:0] LONG_CRC_LAST_CNT  = CNT_W'(LONG_LEN - 9);

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1) accumulator, clear has priority over enable
module sd_crc7
    import cmd_response_deserializer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 7'h00;
        end else if (enable) begin
            crc_d = crc7_step(crc_q, data_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cmd_response_deserializer.sv
// rtl/cmd_response_deserializer.sv - captures 48/136-bit SD CMD responses, checks CRC7 and framing
module cmd_response_deserializer
    import cmd_response_deserializer_pkg::*;
(
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               reset_wrapper,
    input  logic               enable_stp_wrapper,
    input  logic               long_response,
    input  logic               cmd_in,
    output logic [FRAME_W-1:0] pad_response,
    output logic               reception_complete,
    output logic               crc_error,
    output logic               framing_error
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               long_q, long_d;
    logic               tx_err_q, tx_err_d;
    logic               done_q, done_d;
    logic               crc_err_q, crc_err_d;
    logic               frm_err_q, frm_err_d;

    logic               go_idle;
    logic [CNT_W-1:0]   last_cnt;
    logic               crc_in_range;
    logic               crc_enable;
    logic               crc_clear;
    logic [6:0]         crc_val;

    // Long frames skip the 8 header bits; short frames include the start bit, which is a no-op on a zero CRC.
    always_comb begin
        crc_in_range = 1'b0;
        if (long_q) begin
            crc_in_range = (count_q >= LONG_CRC_FIRST_CNT) && (count_q <= LONG_CRC_LAST_CNT);
        end else begin
            crc_in_range = (count_q <= SHORT_CRC_LAST_CNT);
        end
    end

    assign crc_enable = (state_q == S_RECEIVE) && enable_stp_wrapper && crc_in_range;
    assign crc_clear  = reset_wrapper || (state_q != S_RECEIVE);

    sd_crc7 u_crc7 (
        .clk     (sd_clock),
        .rst_n   (reset),
        .clear   (crc_clear),
        .enable  (crc_enable),
        .data_in (cmd_in),
        .crc     (crc_val)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        frame_d   = frame_q;
        long_d    = long_q;
        tx_err_d  = tx_err_q;
        done_d    = done_q;
        crc_err_d = crc_err_q;
        frm_err_d = frm_err_q;
        go_idle   = 1'b0;
        last_cnt  = long_q ? LONG_LAST_CNT : SHORT_LAST_CNT;

        if (reset_wrapper) begin
            go_idle = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_stp_wrapper) begin
                        state_d = S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (!enable_stp_wrapper) begin
                        go_idle = 1'b1;
                    end else if (!cmd_in) begin
                        state_d  = S_RECEIVE;
                        count_d  = CNT_W'(1);
                        long_d   = long_response;
                        frame_d  = '0;
                        tx_err_d = 1'b0;
                    end
                end
                S_RECEIVE: begin
                    if (!enable_stp_wrapper) begin
                        go_idle = 1'b1;
                    end else begin
                        frame_d = {frame_q[FRAME_W-2:0], cmd_in};
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            tx_err_d = cmd_in;
                        end
                        // frame_q[6:0] already holds the received CRC; cmd_in is the end bit.
                        if (count_q == last_cnt) begin
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            crc_err_d = (crc_val != frame_q[6:0]);
                            frm_err_d = tx_err_q | ~cmd_in;
                        end
                    end
                end
                S_DONE: begin
                    if (!enable_stp_wrapper) begin
                        go_idle = 1'b1;
                    end
                end
                default: begin
                    go_idle = 1'b1;
                end
            endcase
        end

        if (go_idle) begin
            state_d   = S_IDLE;
            count_d   = '0;
            frame_d   = '0;
            long_d    = 1'b0;
            tx_err_d  = 1'b0;
            done_d    = 1'b0;
            crc_err_d = 1'b0;
            frm_err_d = 1'b0;
        end
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            frame_q   <= '0;
            long_q    <= 1'b0;
            tx_err_q  <= 1'b0;
            done_q    <= 1'b0;
            crc_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            frame_q   <= frame_d;
            long_q    <= long_d;
            tx_err_q  <= tx_err_d;
            done_q    <= done_d;
            crc_err_q <= crc_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    // Partial frames stay internal; the control block only sees a completed capture.
    assign pad_response       = (state_q == S_DONE) ? frame_q : '0;
    assign reception_complete = done_q;
    assign crc_error          = crc_err_q;
    assign framing_error      = frm_err_q;

endmodule

// File: doc/cmd_response_deserializer.md
CMD_RESPONSE_DESERIALIZER -- requirements
Module: cmd_response_deserializer

Interface
REQ-001 SHALL have ports: sd_clock input 1 -- sole clock; all sampling on rising edge.
REQ-002 SHALL have ports: reset input 1 -- asynchronous, active-low reset.
REQ-003 SHALL have ports: reset_wrapper input 1 -- synchronous clear from the CMD physical-layer control.
REQ-004 SHALL have ports: enable_stp_wrapper input 1 -- arm reception; level-sensitive.
REQ-005 SHALL have ports: long_response input 1 -- 1: 136-bit R2 frame; 0: 48-bit frame; sampled only at start-bit detection.
REQ-006 SHALL have ports: cmd_in input 1 -- serial CMD line from pad; idles high.
REQ-007 SHALL have ports: pad_response output 128 -- received frame to the control block.
REQ-008 SHALL have ports: reception_complete output 1 -- frame captured; level.
REQ-009 SHALL have ports: crc_error output 1 -- CRC7 mismatch for the frame.
REQ-010 SHALL have ports: framing_error output 1 -- transmission bit not 0, or end bit not 1.

Function
REQ-011 SHALL implement one-hot FSM with states IDLE, WAIT_START, RECEIVE, DONE.
REQ-012 IDLE -> WAIT_START when enable_stp_wrapper=1; otherwise stay.
REQ-013 WAIT_START: cmd_in=0 at a rising edge = start bit; -> RECEIVE, bit count=1, latch long_response; cmd_in=1 stays.
REQ-014 RECEIVE: shift cmd_in MSB-first into the frame register each edge; count increments; frame length is 48 (short) or 136 (long).
REQ-015 At the edge sampling the final (end) bit: -> DONE; reception_complete, crc_error and framing_error registered on that same edge.
REQ-016 Short frame: pad_response[47:0] = bits 47..0 as received; pad_response[127:48]=0.
REQ-017 Long frame: pad_response[127:0] = received bits 127..0; header bits 135..128 discarded.
REQ-018 CRC7 polynomial x^7+x^3+1, initial value 0, computed serially during RECEIVE.
REQ-019 Short frame: CRC covers bits 47..8 and is compared with bits 7..1.
REQ-020 Long frame: CRC covers bits 127..8 and is compared with bits 7..1.
REQ-021 framing_error=1 if transmission bit (second bit received) is 1, or end bit is 0; CRC still evaluated.
REQ-022 DONE holds reception_complete=1, pad_response and both error flags stable until reset_wrapper=1 or enable_stp_wrapper=0, then -> IDLE with all outputs cleared.
REQ-023 enable_stp_wrapper=0 in WAIT_START or RECEIVE -> IDLE next edge; partial frame discarded; outputs 0.
REQ-024 reset_wrapper=1 overrides every other input in every state: -> IDLE, outputs 0, counter and CRC cleared next edge.
REQ-025 Block does not implement a response timeout; the control block owns the timeout.
REQ-026 Next start bit is accepted only after passing through IDLE; cmd_in activity in DONE is ignored.

Reset
REQ-027 reset=0 forces asynchronously: state IDLE, pad_response=0, reception_complete=0, crc_error=0, framing_error=0, count=0, CRC=0.
REQ-028 Leaving reset: first active edge evaluates from IDLE.

Structure
REQ-029 Shared package SHALL hold the state encodings (4-bit one-hot), SHORT_LEN=48, LONG_LEN=136 and the CRC7 polynomial constant 7'h09.
REQ-030 Serial CRC7 SHALL be a sub-module sd_crc7 (inputs: clock, reset, clear, enable, data bit; output 7-bit CRC), reusable by the P-S wrapper.
REQ-031 Bit counter SHALL be 8 bits wide.

Verification
REQ-032 Short valid: enable=1, long_response=0, drive model-generated valid 48-bit R1 (CRC from model) -> reception_complete=1 on the edge sampling bit 0; pad_response[47:0] equals frame; errors 0.
REQ-033 Framing: drive 48'h400000000095 (tx bit=1, CRC 0x4A correct) -> reception_complete=1, framing_error=1, crc_error=0.
REQ-034 CRC: valid short frame with bit 20 inverted -> crc_error=1, framing_error=0, reception_complete=1.
REQ-035 Long: long_response=1, valid R2 (header 8'h3F, model CRC) -> pad_response = bits 127..0 after 136 bits; errors 0.
REQ-036 Abort: enable_stp_wrapper dropped after 20 bits, then valid short frame -> first frame discarded; second completes correctly.
REQ-037 Reset: reset=0 asserted mid-RECEIVE, then reset=1 -> all outputs 0 immediately; block in IDLE; reset_wrapper in DONE clears reception_complete next edge.
